// File: rtl/proto_pkg.sv
// Shared types and derivations for the egress deparser.
// PHV byte order: byte i sits at bits [8*i+7:8*i] and overwrites packet byte i.
package proto_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_BODY = 2'd2
    } state_t;

    localparam int PHV_BYTE_W = 8;

    function automatic int beat_bytes(input int data_width);
        return data_width / PHV_BYTE_W;
    endfunction

    function automatic int hdr_beats(input int hdr_bytes, input int data_width);
        return hdr_bytes / beat_bytes(data_width);
    endfunction

endpackage

// File: rtl/proto_byte_merge.sv
// Per-beat masked byte merge of PHV bytes over packet bytes.
// Latency: combinational. Backpressure: none, pure function of inputs.
// Keep is not consulted: masked bytes are replaced even where tkeep is low.
module proto_byte_merge
    import proto_pkg::*;
#(
    parameter int BEAT_BYTES = 32
) (
    input  logic [BEAT_BYTES*PHV_BYTE_W-1:0] data,
    input  logic [BEAT_BYTES*PHV_BYTE_W-1:0] phv,
    input  logic [BEAT_BYTES-1:0]            mask,
    output logic [BEAT_BYTES*PHV_BYTE_W-1:0] merged
);

    always_comb begin
        merged = data;
        for (int b = 0; b < BEAT_BYTES; b++) begin
            if (mask[b]) begin
                merged[b*PHV_BYTE_W +: PHV_BYTE_W] = phv[b*PHV_BYTE_W +: PHV_BYTE_W];
            end
        end
    end

endmodule

// File: rtl/proto_deparse.sv
// Egress deparser: writes masked PHV bytes into the leading packet beats, forwards the stream.
// Latency: 1 clk, 1 beat/clk. Backpressure: single output register, holds while m_axis_tready=0.
// PROTO_DEPARSE_DROP_EN: when defined, phv_drop=1 swallows the whole packet.
module proto_deparse
    import proto_pkg::*;
#(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int HDR_BYTES            = 64
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              s_axis_tlast,
    input  logic [HDR_BYTES*8-1:0]            phv_data,
    input  logic [HDR_BYTES-1:0]              phv_mask,
    input  logic                              phv_drop,
    input  logic                              phv_valid,
    output logic                              phv_ready,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast
);

    localparam int DW         = C_S_AXIS_DATA_WIDTH;
    localparam int BEAT_BYTES = beat_bytes(C_S_AXIS_DATA_WIDTH);
    localparam int HDR_BEATS  = hdr_beats(HDR_BYTES, C_S_AXIS_DATA_WIDTH);
    localparam int CNT_W      = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               drop_pkt;
    logic               acc;
    logic [DW-1:0]      phv_beat;
    logic [BEAT_BYTES-1:0] mask_beat;
    logic [DW-1:0]      merged;
    logic [DW-1:0]      out_data;

`ifndef PROTO_DEPARSE_DROP_EN
    logic unused_drop;
    assign unused_drop = phv_drop;
    assign drop_pkt    = 1'b0;
`endif

    // A dropped packet never occupies the output register, so it need not wait on it.
    assign s_axis_tready = (state != ST_IDLE) && (drop_pkt || !m_axis_tvalid || m_axis_tready);
    assign acc           = s_axis_tvalid && s_axis_tready;
    // Released in the cycle the last beat is taken so upstream can retire the PHV before IDLE looks again.
    assign phv_ready     = acc && s_axis_tlast && !rst;

    always_comb begin
        phv_beat  = '0;
        mask_beat = '0;
        for (int i = 0; i < HDR_BEATS; i++) begin
            if (cnt == CNT_W'(i)) begin
                phv_beat  = phv_data[i*DW +: DW];
                mask_beat = phv_mask[i*BEAT_BYTES +: BEAT_BYTES];
            end
        end
    end

    proto_byte_merge #(
        .BEAT_BYTES (BEAT_BYTES)
    ) u_merge (
        .data   (s_axis_tdata),
        .phv    (phv_beat),
        .mask   (mask_beat),
        .merged (merged)
    );

    assign out_data = (state == ST_HDR) ? merged : s_axis_tdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tlast  <= 1'b0;
`ifdef PROTO_DEPARSE_DROP_EN
            drop_pkt      <= 1'b0;
`endif
        end else begin
            if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            if (acc && !drop_pkt) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= out_data;
                m_axis_tkeep  <= s_axis_tkeep;
                m_axis_tuser  <= s_axis_tuser;
                m_axis_tlast  <= s_axis_tlast;
            end

            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (phv_valid) begin
                        state <= ST_HDR;
`ifdef PROTO_DEPARSE_DROP_EN
                        drop_pkt <= phv_drop;
`endif
                    end
                end
                ST_HDR: begin
                    if (acc) begin
                        if (s_axis_tlast) begin
                            state <= ST_IDLE;
                        end else if (cnt == CNT_W'(HDR_BEATS - 1)) begin
                            state <= ST_BODY;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_BODY: begin
                    if (acc && s_axis_tlast) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_proto_deparse.sv
// Directed bench for proto_deparse: header rewrite, short packets, backpressure, reset, optional drop.
module tb_proto_deparse;

    localparam int DW     = 256;
    localparam int UW     = 128;
    localparam int HB     = 64;
    localparam int BB     = DW / 8;
    localparam int HBEATS = HB / BB;

    logic              clk = 1'b0;
    logic              rst;
    logic [DW-1:0]     s_axis_tdata;
    logic [BB-1:0]     s_axis_tkeep;
    logic [UW-1:0]     s_axis_tuser;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic              s_axis_tlast;
    logic [HB*8-1:0]   phv_data;
    logic [HB-1:0]     phv_mask;
    logic              phv_drop;
    logic              phv_valid;
    logic              phv_ready;
    logic [DW-1:0]     m_axis_tdata;
    logic [BB-1:0]     m_axis_tkeep;
    logic [UW-1:0]     m_axis_tuser;
    logic              m_axis_tvalid;
    logic              m_axis_tready = 1'b1;
    logic              m_axis_tlast;

    proto_deparse dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .phv_data      (phv_data),
        .phv_mask      (phv_mask),
        .phv_drop      (phv_drop),
        .phv_valid     (phv_valid),
        .phv_ready     (phv_ready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [BB-1:0] keep;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    beat_t         exp_q[$];
    logic [DW-1:0] out_log[$];
    int n_checks = 0;
    int n_fail   = 0;
    int phv_rdy_cnt = 0;
    int out_cnt  = 0;
    int in_cnt   = 0;
    logic       tog_en = 1'b0;
    logic [3:0] tog_pat = 4'b1001;
    int         tog_idx = 0;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk_data(input int pkt, input int k);
        logic [DW-1:0] r;
        for (int b = 0; b < BB; b++) r[b*8 +: 8] = 8'(pkt*64 + k*32 + b);
        return r;
    endfunction

    function automatic logic [DW-1:0] model_beat(input logic [DW-1:0] d, input int k);
        logic [DW-1:0] r;
        r = d;
        if (k < HBEATS) begin
            for (int b = 0; b < BB; b++) begin
                if (phv_mask[k*BB + b]) r[b*8 +: 8] = phv_data[(k*BB + b)*8 +: 8];
            end
        end
        return r;
    endfunction

    // Downstream ready: steady 1, or the 1,0,0,1 pattern while tog_en is set.
    always @(posedge clk) begin
        #1;
        if (tog_en) begin
            m_axis_tready = tog_pat[tog_idx];
            tog_idx = (tog_idx + 1) % 4;
        end else begin
            m_axis_tready = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (phv_ready) phv_rdy_cnt++;
        if (m_axis_tvalid && m_axis_tready) begin
            out_cnt++;
            out_log.push_back(m_axis_tdata);
            if (exp_q.size() == 0) begin
                chk("spurious_beat", exp_q.size(), 1);
            end else begin
                chk("out_beat", {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast}, exp_q.pop_front());
            end
        end
    end

    task automatic wait_accept();
        int n;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (s_axis_tready) break;
            n++;
            if (n > 200) begin
                chk("accept_timeout", n, 0);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_cnt++;
    endtask

    task automatic send_pkt(input int pkt, input int nbeats, input logic [BB-1:0] keep, input logic drop);
        beat_t e;
        phv_drop  = drop;
        phv_valid = 1'b1;
        for (int k = 0; k < nbeats; k++) begin
            s_axis_tdata  = mk_data(pkt, k);
            s_axis_tkeep  = keep;
            s_axis_tuser  = UW'(pkt*256 + k);
            s_axis_tlast  = (k == nbeats - 1);
            s_axis_tvalid = 1'b1;
            e.data = model_beat(s_axis_tdata, k);
            e.keep = keep;
            e.user = s_axis_tuser;
            e.last = s_axis_tlast;
            if (!drop) exp_q.push_back(e);
            wait_accept();
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        phv_valid     = 1'b0;
        phv_drop      = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (n >= 100) chk("drain_timeout", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int p0, o0, i0, base;
        logic [DW-1:0] v, ref_d;

        rst = 1'b1;
        s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tuser = '0;
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        phv_data = '0; phv_mask = '0; phv_drop = 1'b0; phv_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_m_tvalid", m_axis_tvalid, 0);
        chk("rst_m_tdata",  m_axis_tdata, 0);
        chk("rst_m_tuser",  {m_axis_tkeep, m_axis_tuser, m_axis_tlast}, 0);
        chk("rst_phv_ready", phv_ready, 0);
        chk("rst_s_tready", s_axis_tready, 0);
        @(posedge clk);
        #1;

        // Full mask: two header beats replaced, third passes through.
        for (int i = 0; i < HB; i++) phv_data[i*8 +: 8] = 8'(8'hA0 + i);
        phv_mask = '1;
        p0 = phv_rdy_cnt; base = out_log.size();
        send_pkt(1, 3, '1, 1'b0);
        drain();
        chk("t1_phv_ready", phv_rdy_cnt - p0, 1);
        v = out_log[base];
        chk("t1_b0_byte0", v[7:0], 8'hA0);
        v = out_log[base+1];
        chk("t1_b1_byte31", v[255:248], 8'hDF);
        chk("t1_b2_pass", out_log[base+2], mk_data(1, 2));

        // Only bytes 0-3 of beat 0 are replaced.
        phv_mask = 64'h0000_0000_0000_000F;
        base = out_log.size();
        send_pkt(2, 3, '1, 1'b0);
        drain();
        v = out_log[base];
        ref_d = mk_data(2, 0);
        chk("t2_b0_byte3", v[31:24], 8'hA3);
        chk("t2_b0_byte4", v[39:32], 8'h84);
        chk("t2_b0_upper", v[DW-1:32], ref_d[DW-1:32]);
        chk("t2_b1_pass", out_log[base+1], mk_data(2, 1));

        // Single-beat packet with partial keep, then a stall until a new PHV arrives.
        phv_mask = '1;
        p0 = phv_rdy_cnt; base = out_log.size();
        send_pkt(3, 1, 32'h0000_FFFF, 1'b0);
        drain();
        chk("t3_phv_ready", phv_rdy_cnt - p0, 1);
        v = out_log[base];
        chk("t3_b0_byte0", v[7:0], 8'hA0);
        o0 = out_cnt;
        s_axis_tdata = mk_data(4, 0); s_axis_tkeep = '1; s_axis_tlast = 1'b1; s_axis_tvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t3_stall_tready", s_axis_tready, 0);
        end
        chk("t3_stall_no_out", out_cnt - o0, 0);
        @(posedge clk);
        #1;
        send_pkt(4, 1, '1, 1'b0);
        drain();

        // Backpressure 1,0,0,1 across a 5-beat packet.
        phv_mask = 64'h00FF_0000_0000_F00F;
        p0 = phv_rdy_cnt; o0 = out_cnt;
        tog_en = 1'b1;
        send_pkt(5, 5, '1, 1'b0);
        drain();
        tog_en = 1'b0;
        drain();
        chk("t4_out_count", out_cnt - o0, 5);
        chk("t4_phv_ready", phv_rdy_cnt - p0, 1);

        // Reset during beat 1 of a 4-beat packet.
        begin
            beat_t e;
            phv_mask = '1;
            p0 = phv_rdy_cnt;
            phv_valid = 1'b1;
            s_axis_tdata = mk_data(6, 0); s_axis_tkeep = '1; s_axis_tuser = UW'(6*256);
            s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1;
            e.data = model_beat(s_axis_tdata, 0); e.keep = '1; e.user = s_axis_tuser; e.last = 1'b0;
            exp_q.push_back(e);
            wait_accept();
            s_axis_tdata = mk_data(6, 1); s_axis_tuser = UW'(6*256 + 1);
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0; s_axis_tvalid = 1'b0; phv_valid = 1'b0;
            @(negedge clk);
            chk("t5_m_tvalid", m_axis_tvalid, 0);
            chk("t5_s_tready_idle", s_axis_tready, 0);
            chk("t5_phv_ready", phv_rdy_cnt - p0, 0);
            chk("t5_queue", exp_q.size(), 0);
            @(posedge clk);
            #1;
        end

`ifdef PROTO_DEPARSE_DROP_EN
        phv_mask = '1;
        p0 = phv_rdy_cnt; o0 = out_cnt; i0 = in_cnt;
        send_pkt(7, 4, '1, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        chk("t6_in_count", in_cnt - i0, 4);
        chk("t6_out_count", out_cnt - o0, 0);
        chk("t6_phv_ready", phv_rdy_cnt - p0, 1);
        o0 = out_cnt;
        send_pkt(8, 2, '1, 1'b0);
        drain();
        chk("t6_next_out", out_cnt - o0, 2);
`endif

        repeat (5) @(posedge clk);
        chk("final_queue", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/proto_deparse.md
Name: proto_deparse

Overview:
- Egress counterpart of the ingress protocol-processing stage.
- Takes a packet on AXI-Stream plus one header vector (PHV) per packet, produced upstream as a byte blob with a per-byte write mask.
- Overwrites the masked header bytes in the leading beats of the packet, then forwards the packet on a master AXI-Stream.
- Sits between the match/action logic and the MAC-side TX path.

Parameters:
- C_S_AXIS_DATA_WIDTH, 256, stream data width in bits; multiple of 8.
- C_S_AXIS_TUSER_WIDTH, 128, tuser width; passed through unchanged.
- HDR_BYTES, 64, PHV header bytes; integer multiple of C_S_AXIS_DATA_WIDTH/8.

Ports:
- clk  in  1  stream clock.
- rst  in  1  synchronous reset, active-high.
- s_axis_tdata  in  C_S_AXIS_DATA_WIDTH  packet data.
- s_axis_tkeep  in  C_S_AXIS_DATA_WIDTH/8  byte enables.
- s_axis_tuser  in  C_S_AXIS_TUSER_WIDTH  sideband.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tready  out  1  beat accept.
- s_axis_tlast  in  1  last beat.
- phv_data  in  HDR_BYTES*8  header bytes; byte 0 = bits [7:0] = packet byte 0.
- phv_mask  in  HDR_BYTES  1 = replace that packet byte.
- phv_drop  in  1  discard the packet (used only with the optional feature).
- phv_valid  in  1  PHV available.
- phv_ready  out  1  PHV consumed; one-cycle pulse.
- m_axis_tdata  out  C_S_AXIS_DATA_WIDTH  rewritten data.
- m_axis_tkeep  out  C_S_AXIS_DATA_WIDTH/8  equals input tkeep.
- m_axis_tuser  out  C_S_AXIS_TUSER_WIDTH  equals input tuser.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream accept.
- m_axis_tlast  out  1  last beat.

Behaviour:
- Reset values (rst high at a clk edge):
  - m_axis_tvalid=0, m_axis_tdata/tkeep/tuser/tlast=0.
  - phv_ready=0, state=IDLE, beat counter=0.
- Constants: BEAT_BYTES=C_S_AXIS_DATA_WIDTH/8; HDR_BEATS=HDR_BYTES/BEAT_BYTES.
- States:
  - IDLE: wait for phv_valid; s_axis_tready=0.
  - HDR: beats 0..HDR_BEATS-1 of the packet; counter cnt counts beats.
  - BODY: beats at or beyond HDR_BEATS; pass through.
- Transitions:
  - IDLE->HDR when phv_valid=1. The PHV is held on the inputs (phv_valid stays high) until phv_ready pulses.
  - HDR->BODY on an accepted non-last beat when cnt==HDR_BEATS-1.
  - HDR or BODY -> IDLE on an accepted beat with tlast=1. phv_ready=1 in that same cycle.
- Output register is a single stage: s_axis_tready = (state!=IDLE) && (!m_axis_tvalid || m_axis_tready).
- Latency 1 clk input-to-output. Throughput 1 beat/clk under no backpressure.
- Rewrite in HDR: output byte b of beat cnt = phv_mask[cnt*BEAT_BYTES+b] ? phv byte : input byte.
  - Applies even when tkeep[b]=0; tkeep itself is never modified.
- BODY beats are forwarded bit-exact.
- Short packet (tlast before HDR_BEATS beats): remaining PHV bytes are ignored. PHV is released on that tlast; return to IDLE.
- Single-beat packet: phv_ready pulses on that beat; the next packet needs a new PHV.
- Backpressure: output registers hold while m_axis_tvalid=1 and m_axis_tready=0. No beat is lost or duplicated.
- phv_valid falling mid-packet is a protocol violation; behaviour is undefined and need not be checked.
- rst mid-packet: state returns to IDLE, the in-flight output beat is discarded, and no phv_ready is issued.

Optional Feature:
- Macro: PROTO_DEPARSE_DROP_EN.
- Defined:
  - phv_drop is sampled at IDLE->HDR.
  - If 1, all beats of the packet are accepted (s_axis_tready = state!=IDLE) but never presented: m_axis_tvalid stays 0.
  - phv_ready pulses on tlast as usual.
- Undefined: phv_drop is ignored and all packets are forwarded.

Decomposition:
- Package proto_pkg holds:
  - state encoding constants ST_IDLE/ST_HDR/ST_BODY.
  - BEAT_BYTES and HDR_BEATS derivation functions.
  - PHV byte-order convention.
- One natural sub-module: proto_byte_merge. It is combinational and computes the per-beat masked merge from (data, phv slice, mask slice).
- FSM and output register stay in proto_deparse.

Test Plan:
- Default params; 3-beat packet; PHV bytes 0..63 = 0xA0+i; mask = all-ones -> beats 0,1 fully replaced, beat 2 unchanged; phv_ready pulses once on beat 2.
- Mask = 0x...000F (bytes 0-3 only) -> only out bytes 0-3 of beat 0 changed; all other bytes equal input.
- 1-beat packet, tlast on beat 0, tkeep=0x0000FFFF -> beat 0 rewritten, tkeep out 0x0000FFFF, phv_ready pulses; next packet stalls (s_axis_tready=0) until a new phv_valid.
- m_axis_tready toggles 1,0,0,1 across a 5-beat packet -> output sequence identical to input order, no drops or duplicates, tuser preserved.
- Assert rst for one cycle during beat 1 of a 4-beat packet -> m_axis_tvalid=0 the next cycle, no phv_ready, state IDLE.
- With PROTO_DEPARSE_DROP_EN and phv_drop=1 on a 4-beat packet -> zero output beats, 4 input beats accepted, phv_ready pulses on tlast; the following packet with drop=0 passes normally.
